// File: rtl/seg_pkg.sv
// Shared types and parameter defaults for the payload segmenter.
// Optional pad-length output is enabled by defining PAYLOAD_PAD_EN.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } seg_state_e;

  localparam int DEF_LEN_W        = 16;
  localparam int DEF_MAX_PAYLOAD  = 1500;
  localparam int DEF_SPLIT_THRESH = 1600;
  localparam int DEF_MIN_PAYLOAD  = 46;

endpackage

// File: rtl/seg_len_calc.sv
// Combinational segment sizing: remaining bytes -> next segment length and last flag.
// Pad length is produced only when PAYLOAD_PAD_EN is defined.
module seg_len_calc #(
  parameter int LEN_W        = 16,
  parameter int MAX_PAYLOAD  = 1500,
  parameter int SPLIT_THRESH = 1600
`ifdef PAYLOAD_PAD_EN
  ,parameter int MIN_PAYLOAD = 46
`endif
) (
  input  logic [LEN_W-1:0] i_remain,
  output logic [LEN_W-1:0] o_seg_len,
  output logic             o_seg_last
`ifdef PAYLOAD_PAD_EN
  ,output logic [LEN_W-1:0] o_pad_len
`endif
);

  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_PAYLOAD);
  localparam logic [LEN_W-1:0] SPLIT_L = LEN_W'(SPLIT_THRESH);

  logic [LEN_W-1:0] w_half;
  logic [LEN_W-1:0] w_len;

  // (rem+1)>>1 expressed as (rem>>1)+rem[0]; the carry bit of the wide sum is always zero
  assign w_half = {1'b0, i_remain[LEN_W-1:1]} + {{(LEN_W-1){1'b0}}, i_remain[0]};

  // Cap at MAX, halve a tail in (MAX, SPLIT] so no runt frame follows, else send the rest
  always_comb begin
    w_len = i_remain;
    if (i_remain > SPLIT_L) begin
      w_len = MAX_L;
    end else if (i_remain > MAX_L) begin
      w_len = w_half;
    end else begin
      w_len = i_remain;
    end
  end

  assign o_seg_len  = w_len;
  assign o_seg_last = (w_len == i_remain);

`ifdef PAYLOAD_PAD_EN
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_PAYLOAD);
  assign o_pad_len = (w_len < MIN_L) ? (MIN_L - w_len) : {LEN_W{1'b0}};
`endif

endmodule

// File: rtl/seg_param_chk.sv
// Elaboration-time guard on the segmenter's parameter relationships.
// The MIN_PAYLOAD check exists only when PAYLOAD_PAD_EN is defined.
module seg_param_chk #(
  parameter int LEN_W        = 16,
  parameter int MAX_PAYLOAD  = 1500,
  parameter int SPLIT_THRESH = 1600
`ifdef PAYLOAD_PAD_EN
  ,parameter int MIN_PAYLOAD = 46
`endif
) ();

  if (!(SPLIT_THRESH > MAX_PAYLOAD && SPLIT_THRESH <= 2 * MAX_PAYLOAD)) begin : g_bad_split
    $error("seg_param_chk: need MAX_PAYLOAD < SPLIT_THRESH <= 2*MAX_PAYLOAD");
  end

  if (SPLIT_THRESH >= (1 << LEN_W)) begin : g_bad_width
    $error("seg_param_chk: SPLIT_THRESH does not fit in LEN_W bits");
  end

`ifdef PAYLOAD_PAD_EN
  if (MIN_PAYLOAD > MAX_PAYLOAD) begin : g_bad_min
    $error("seg_param_chk: need MIN_PAYLOAD <= MAX_PAYLOAD");
  end
`endif

endmodule

// File: rtl/payload_segmenter.sv
// Splits a transfer byte count into per-frame payload lengths with valid/ready on both sides.
// Define PAYLOAD_PAD_EN to add the pad_len output (bytes needed to reach MIN_PAYLOAD).
module payload_segmenter
  import seg_pkg::*;
#(
  parameter int LEN_W        = DEF_LEN_W,
  parameter int MAX_PAYLOAD  = DEF_MAX_PAYLOAD,
  parameter int SPLIT_THRESH = DEF_SPLIT_THRESH
`ifdef PAYLOAD_PAD_EN
  ,parameter int MIN_PAYLOAD = DEF_MIN_PAYLOAD
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [LEN_W-1:0] req_bytes,
  input  logic             abort,
  output logic             seg_valid,
  input  logic             seg_ready,
  output logic [LEN_W-1:0] seg_len,
  output logic             seg_last,
  output logic [LEN_W-1:0] seg_idx,
  output logic             busy,
  output logic             done
`ifdef PAYLOAD_PAD_EN
  ,output logic [LEN_W-1:0] pad_len
`endif
);

  seg_state_e       r_state;
  logic [LEN_W-1:0] r_remain;
  logic [LEN_W-1:0] r_seg_len;
  logic [LEN_W-1:0] r_seg_idx;
  logic             r_seg_last;
  logic             r_seg_valid;
  logic             r_done;
  logic             r_busy;
  logic             r_req_ready;
  logic [LEN_W-1:0] w_calc_len;
  logic             w_calc_last;
`ifdef PAYLOAD_PAD_EN
  logic [LEN_W-1:0] r_pad_len;
  logic [LEN_W-1:0] w_calc_pad;
`endif

`ifdef PAYLOAD_PAD_EN
  seg_param_chk #(.LEN_W(LEN_W), .MAX_PAYLOAD(MAX_PAYLOAD), .SPLIT_THRESH(SPLIT_THRESH),
                  .MIN_PAYLOAD(MIN_PAYLOAD)) u_param_chk ();

  seg_len_calc #(.LEN_W(LEN_W), .MAX_PAYLOAD(MAX_PAYLOAD), .SPLIT_THRESH(SPLIT_THRESH),
                 .MIN_PAYLOAD(MIN_PAYLOAD)) u_calc (
    .i_remain   (r_remain),
    .o_seg_len  (w_calc_len),
    .o_seg_last (w_calc_last),
    .o_pad_len  (w_calc_pad)
  );
`else
  seg_param_chk #(.LEN_W(LEN_W), .MAX_PAYLOAD(MAX_PAYLOAD), .SPLIT_THRESH(SPLIT_THRESH)) u_param_chk ();

  seg_len_calc #(.LEN_W(LEN_W), .MAX_PAYLOAD(MAX_PAYLOAD), .SPLIT_THRESH(SPLIT_THRESH)) u_calc (
    .i_remain   (r_remain),
    .o_seg_len  (w_calc_len),
    .o_seg_last (w_calc_last)
  );
`endif

  // Segmenting FSM; abort takes priority over any request or handshake in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_remain    <= {LEN_W{1'b0}};
      r_seg_len   <= {LEN_W{1'b0}};
      r_seg_idx   <= {LEN_W{1'b0}};
      r_seg_last  <= 1'b0;
      r_seg_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_req_ready <= 1'b1;
`ifdef PAYLOAD_PAD_EN
      r_pad_len   <= {LEN_W{1'b0}};
`endif
    end else if (abort) begin
      r_state     <= IDLE;
      r_remain    <= {LEN_W{1'b0}};
      r_seg_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_req_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_remain    <= req_bytes;
            r_seg_idx   <= {LEN_W{1'b0}};
            r_state     <= CALC;
            r_busy      <= 1'b1;
            r_req_ready <= 1'b0;
          end
        end
        CALC: begin
          if (r_remain == {LEN_W{1'b0}}) begin
            r_done      <= 1'b1;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
          end else begin
            r_seg_len   <= w_calc_len;
            r_seg_last  <= w_calc_last;
`ifdef PAYLOAD_PAD_EN
            r_pad_len   <= w_calc_pad;
`endif
            r_seg_valid <= 1'b1;
            r_state     <= EMIT;
          end
        end
        EMIT: begin
          if (seg_ready) begin
            r_remain    <= r_remain - r_seg_len;
            r_seg_idx   <= r_seg_idx + {{(LEN_W-1){1'b0}}, 1'b1};
            r_seg_valid <= 1'b0;
            if (r_seg_last) begin
              r_done      <= 1'b1;
              r_state     <= IDLE;
              r_busy      <= 1'b0;
              r_req_ready <= 1'b1;
            end else begin
              r_state <= CALC;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_seg_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign seg_valid = r_seg_valid;
  assign seg_len   = r_seg_len;
  assign seg_last  = r_seg_last;
  assign seg_idx   = r_seg_idx;
  assign busy      = r_busy;
  assign done      = r_done;
`ifdef PAYLOAD_PAD_EN
  assign pad_len   = r_pad_len;
`endif

endmodule

// File: tb/tb_payload_segmenter.sv
// Randomized self-checking bench for payload_segmenter against a queue-based segment-list model.
// Pad-length checks are compiled in when PAYLOAD_PAD_EN is defined.
module tb_payload_segmenter;

  localparam int LEN_W = 16;
  localparam int MAXP  = 1500;
  localparam int SPL   = 1600;
  localparam int MINP  = 46;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [LEN_W-1:0] req_bytes;
  logic             abort;
  logic             seg_valid;
  logic             seg_ready;
  logic [LEN_W-1:0] seg_len;
  logic             seg_last;
  logic [LEN_W-1:0] seg_idx;
  logic             busy;
  logic             done;
`ifdef PAYLOAD_PAD_EN
  logic [LEN_W-1:0] pad_len;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  payload_segmenter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_bytes (req_bytes),
    .abort     (abort),
    .seg_valid (seg_valid),
    .seg_ready (seg_ready),
    .seg_len   (seg_len),
    .seg_last  (seg_last),
    .seg_idx   (seg_idx),
    .busy      (busy),
    .done      (done)
`ifdef PAYLOAD_PAD_EN
    ,.pad_len  (pad_len)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: list of segment lengths for a transfer, straight from the sizing rules
  task automatic build_model(input int bytes);
    int r;
    r = bytes;
    exp_q.delete();
    while (r > 0) begin
      int s;
      if (r > SPL)       s = MAXP;
      else if (r > MAXP) s = (r + 1) / 2;
      else               s = r;
      exp_q.push_back(s);
      r -= s;
    end
  endtask

  task automatic run_xfer(input int bytes, input int stall_pct, input int hold_idx, input bit noise);
    int  k = 0;
    int  n = 0;
    int  held = 0;
    bit  prev_hs = 1'b0;
    bit  got_done = 1'b0;
    bit  first_seen = 1'b0;
    bit  rdy;
    build_model(bytes);
    @(negedge clk);
    check_eq("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_bytes = bytes[LEN_W-1:0];
    seg_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    while (!got_done && n < 4000) begin
      n++;
      if (prev_hs || n == 1) check_eq("calc_bubble", seg_valid, 0);
      if (done) begin
        got_done = 1'b1;
        check_eq("done_seg_count", k, exp_q.size());
        check_eq("done_busy", busy, 0);
        if (exp_q.size() == 0) check_eq("zero_done_lat", n, 2);
      end else if (seg_valid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          check_eq("first_seg_lat", n, 2);
        end
        check_eq("busy_ready_low", {busy, req_ready}, 2'b10);
        if (k < exp_q.size()) begin
          check_eq("seg_len", seg_len, exp_q[k]);
          check_eq("seg_last", seg_last, (k == exp_q.size() - 1) ? 1 : 0);
          check_eq("seg_idx", seg_idx, k);
`ifdef PAYLOAD_PAD_EN
          check_eq("pad_len", pad_len, (exp_q[k] < MINP) ? MINP - exp_q[k] : 0);
`endif
        end else begin
          check_eq("extra_segment", k, exp_q.size());
        end
        if (k == hold_idx && held < 5) begin
          rdy = 1'b0;
          held++;
        end else begin
          rdy = ($urandom_range(0, 99) >= stall_pct);
        end
        seg_ready = rdy;
        prev_hs = rdy;
        if (rdy) k++;
      end else begin
        prev_hs = 1'b0;
        seg_ready = 1'($urandom_range(0, 1));
      end
      if (!got_done) begin
        if (noise) begin
          req_valid = 1'($urandom_range(0, 1));
          req_bytes = LEN_W'($urandom);
        end
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    seg_ready = 1'b0;
    if (!got_done) check_eq("xfer_timeout", 0, 1);
    @(negedge clk);
    check_eq("post_done_idle", {done, busy, req_ready, seg_valid}, 4'b0010);
  endtask

  initial begin
    int b;
    int guard;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_bytes = '0;
    abort     = 1'b0;
    seg_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_valid_last_done", {seg_valid, seg_last, done, busy}, 4'b0000);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_seg_len", seg_len, 0);
    check_eq("rst_seg_idx", seg_idx, 0);
`ifdef PAYLOAD_PAD_EN
    check_eq("rst_pad_len", pad_len, 0);
`endif

    run_xfer(3000, 0, -1, 1'b0);
    run_xfer(3100, 0, -1, 1'b0);
    run_xfer(1551, 0, -1, 1'b0);
    run_xfer(0, 0, -1, 1'b0);
    run_xfer(4000, 0, 1, 1'b0);
    run_xfer(40, 0, -1, 1'b0);
    run_xfer(1546, 0, -1, 1'b0);
    run_xfer(1500, 20, -1, 1'b1);
    run_xfer(1501, 20, -1, 1'b1);
    run_xfer(1600, 20, -1, 1'b1);
    run_xfer(1601, 20, -1, 1'b1);
    run_xfer(3001, 30, -1, 1'b1);
    run_xfer(1, 30, -1, 1'b1);
    run_xfer(65535, 10, -1, 1'b1);

    // Abort on segment 1 of a 3000-byte transfer, same cycle as the handshake
    @(negedge clk);
    req_valid = 1'b1;
    req_bytes = 16'd3000;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!(seg_valid && seg_idx == 16'd1) && guard < 20) begin
      seg_ready = seg_valid;
      guard++;
      @(negedge clk);
    end
    check_eq("abort_reach_seg1", (guard < 20) ? 1 : 0, 1);
    check_eq("abort_seg1_len", seg_len, 1500);
    seg_ready = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    seg_ready = 1'b0;
    check_eq("abort_state", {seg_valid, busy, req_ready, done}, 4'b0010);
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_no_done", {done, seg_valid}, 2'b00);
    end
    run_xfer(100, 0, -1, 1'b0);

    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 100);
        1:       b = $urandom_range(1400, 1700);
        2:       b = $urandom_range(0, 6000);
        default: b = $urandom_range(0, 65535);
      endcase
      run_xfer(b, $urandom_range(0, 50), -1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
